cell_vector_checker: RTL and testbench

- Sequential stimulus/response checker for a combinational standard cell under test, e.g. AOI21X1 (Y = ~((A&B)|C)).
- Drives all 2^N_IN input vectors onto the cell in order and waits a programmable settle time before each sample.
- Samples the cell output and compares it against a parameterised truth table; reports mismatch count, first failing vector and pass/fail.
- Sits in the cell-library silicon-test harness, between the test sequencer (start/abort) and the cell pins.

---
 rtl/cell_chk_pkg.sv | 22 ++
 rtl/cell_settle_ctr.sv | 26 ++
 rtl/cell_vector_checker.sv | 136 +++++++++++++
 tb/tb_cell_vector_checker.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_chk_pkg.sv
// Shared types and truth-table constants
// for the standard-cell vector checker.
package cell_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  localparam logic [7:0] AOI21_TT = 8'h07;
  localparam logic [7:0] NAND3_TT = 8'h7F;
  localparam logic [7:0] OAI21_TT = 8'h1F;

  function automatic logic expected(
    input logic [255:0] tt,
    input logic [7:0]   vec
  );
    return tt[vec];
  endfunction

endpackage

// File: rtl/cell_settle_ctr.sv
// Loadable 4-bit down-counter that
// paces the settle wait per vector.
module cell_settle_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] value,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= value;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/cell_vector_checker.sv
// Sweeps every input vector onto a cell,
// samples its output after a settle wait.
module cell_vector_checker #(
  parameter int N_IN = 3,
  parameter logic [2**N_IN-1:0] TRUTH = 8'h07,
  parameter int SETTLE = 2,
  parameter int CW = 8
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   err_count,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid
);

  import cell_chk_pkg::*;

  localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};
  localparam logic [CW-1:0] ERR_MAX = {CW{1'b1}};

  state_t          state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   err_q, err_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            fval_q, fval_d;
  logic            load, dec, zero, miss;

  cell_settle_ctr u_ctr (
    .clk   (CLK),
    .rst_n (R),
    .load  (load),
    .dec   (dec),
    .value (4'(SETTLE)),
    .zero  (zero)
  );

  assign miss = (dut_y != expected(256'(TRUTH), 8'(stim_q)));

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      fval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fval_q  <= fval_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fval_d  = fval_q;
    load    = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          stim_d  = '0;
          load    = 1'b1;
          err_d   = '0;
          fval_d  = 1'b0;
          fvec_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          stim_d  = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (!zero) begin
          dec = 1'b1;
        end else begin
          if (miss) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (!fval_q) begin
              fvec_d = stim_q;
              fval_d = 1'b1;
            end
          end
          if (stim_q != LAST) begin
            stim_d = stim_q + 1'b1;
            load   = 1'b1;
          end else begin
            // final compare is folded into pass
            state_d = ST_DONE;
            busy_d  = 1'b0;
            stim_d  = '0;
            pass_d  = (err_d == '0);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_vec   = fvec_q;
  assign fail_valid = fval_q;

endmodule

// File: tb/tb_cell_vector_checker.sv
// Self-checking bench: four checker instances
// against a transaction-level sweep model.
module tb_cell_vector_checker;

  localparam int NI = 4;
  localparam int ST [NI] = '{2, 2, 0, 1};
  localparam int CWS[NI] = '{8, 2, 8, 8};
  localparam logic [7:0] TT = 8'h07;

  logic CLK = 1'b0;
  logic R = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic chk_on = 1'b0;

  logic [NI-1:0] busy, done, pass, fval;
  logic [2:0] stim [NI];
  logic [2:0] fvec [NI];
  logic [7:0] err  [NI];

  // 0 ideal, 1 stuck-1, 2 stuck-0, 3 one cycle late, 4 random
  int   mode  [NI];
  logic rnd_y [NI];

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CWS[g]-1:0] e;
    logic [2:0] s, fv;
    logic yl, dy;
    logic [7:0] tt_v;

    assign tt_v = TT;

    cell_vector_checker #(
      .N_IN   (3),
      .TRUTH  (TT),
      .SETTLE (ST[g]),
      .CW     (CWS[g])
    ) u_dut (
      .CLK        (CLK),
      .R          (R),
      .start      (start),
      .abort      (abort),
      .dut_y      (dy),
      .stim       (s),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .err_count  (e),
      .fail_vec   (fv),
      .fail_valid (fval[g])
    );

    assign stim[g] = s;
    assign fvec[g] = fv;
    assign err[g]  = 8'(e);

    always @(posedge CLK) yl <= tt_v[s];

    always_comb begin
      dy = tt_v[s];
      if (mode[g] == 1) dy = 1'b1;
      else if (mode[g] == 2) dy = 1'b0;
      else if (mode[g] == 3) dy = yl;
      else if (mode[g] == 4) dy = rnd_y[g];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d",
                 nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 sweeping, 2 done cycle.
  // t counts edges since the accepted start edge.
  int   ph   [NI];
  int   t    [NI];
  int   mism [NI];
  int   fv_m [NI];
  logic fl_m [NI];
  logic ps_m [NI];

  function automatic logic drv(input int i,
                               input int v,
                               input int te);
    int sp;
    logic [7:0] tt;
    sp = ST[i] + 1;
    tt = TT;
    case (mode[i])
      1: return 1'b1;
      2: return 1'b0;
      3: return tt[(te >= 2) ? (te - 2) / sp : 0];
      4: return rnd_y[i];
      default: return tt[v];
    endcase
  endfunction

  always @(posedge CLK or negedge R) begin
    if (!R) begin
      for (int i = 0; i < NI; i++) begin
        ph[i] = 0; t[i] = 0; mism[i] = 0;
        fv_m[i] = 0; fl_m[i] = 0; ps_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        int sp, v;
        logic yv;
        logic [7:0] tt;
        tt = TT;
        sp = ST[i] + 1;
        if (ph[i] == 0) begin
          if (start) begin
            ph[i] = 1; t[i] = 0; mism[i] = 0;
            fv_m[i] = 0; fl_m[i] = 0; ps_m[i] = 0;
          end
        end else if (ph[i] == 2) begin
          ph[i] = 0;
        end else begin
          t[i]++;
          if (abort) begin
            ph[i] = 0;
            ps_m[i] = 0;
          end else if (t[i] % sp == 0) begin
            v = t[i] / sp - 1;
            yv = drv(i, v, t[i]);
            if (yv !== tt[v]) begin
              mism[i]++;
              if (!fl_m[i]) begin
                fv_m[i] = v;
                fl_m[i] = 1;
              end
            end
            if (v == 7) begin
              ph[i] = 2;
              ps_m[i] = (mism[i] == 0);
            end
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        int sp, emax, ee;
        sp = ST[i] + 1;
        emax = (1 << CWS[i]) - 1;
        ee = (mism[i] < emax) ? mism[i] : emax;
        chk($sformatf("stim%0d", i), 32'(stim[i]),
            32'((ph[i] == 1) ? t[i] / sp : 0));
        chk($sformatf("busy%0d", i), 32'(busy[i]),
            32'(ph[i] == 1));
        chk($sformatf("done%0d", i), 32'(done[i]),
            32'(ph[i] == 2));
        chk($sformatf("pass%0d", i), 32'(pass[i]),
            32'(ps_m[i]));
        chk($sformatf("err%0d", i), 32'(err[i]),
            32'(ee));
        chk($sformatf("fvec%0d", i), 32'(fvec[i]),
            32'(fv_m[i]));
        chk($sformatf("fval%0d", i), 32'(fval[i]),
            32'(fl_m[i]));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done0(input string nm, output int n);
    n = 1;
    while (!done[0] && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!done[0]) chk({nm, "_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic wait_stim0(input logic [2:0] v);
    int n;
    n = 0;
    while (stim[0] !== v && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (stim[0] !== v) chk("stim_wait_timeout", 32'(stim[0]), 32'(v));
  endtask

  initial begin
    int n, seen;
    for (int i = 0; i < NI; i++) begin
      mode[i] = 0;
      rnd_y[i] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    chk("rst_stim", 32'(stim[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_pass", 32'(pass[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_fval", 32'(fval[0]), 32'd0);
    R = 1'b1;
    chk_on = 1'b1;
    @(negedge CLK);

    // ideal, stuck-0 with CW=2, late at SETTLE 0 and 1
    mode[0] = 0; mode[1] = 2; mode[2] = 3; mode[3] = 3;
    pulse_start();
    wait_done0("ideal", n);
    chk("ideal_done_cycle", 32'(n), 32'd25);
    chk("ideal_pass", 32'(pass[0]), 32'd1);
    chk("ideal_err", 32'(err[0]), 32'd0);
    chk("ideal_fval", 32'(fval[0]), 32'd0);
    chk("sat_err", 32'(err[1]), 32'd3);
    chk("sat_fvec", 32'(fvec[1]), 32'd0);
    chk("sat_pass", 32'(pass[1]), 32'd0);
    chk("late_s1_pass", 32'(pass[3]), 32'd1);
    repeat (4) @(negedge CLK);

    // stuck-1 with an ignored start mid-sweep
    mode[0] = 1;
    pulse_start();
    repeat (10) @(negedge CLK);
    pulse_start();
    wait_done0("stuck1", n);
    chk("stuck1_cycle", 32'(n), 32'd14);
    chk("stuck1_err", 32'(err[0]), 32'd5);
    chk("stuck1_fvec", 32'(fvec[0]), 32'd3);
    chk("stuck1_fval", 32'(fval[0]), 32'd1);
    chk("stuck1_pass", 32'(pass[0]), 32'd0);
    repeat (30) @(negedge CLK);

    // abort once vector 4 is on the pins
    pulse_start();
    wait_stim0(3'd4);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_stim", 32'(stim[0]), 32'd0);
    chk("abort_err", 32'(err[0]), 32'd1);
    chk("abort_fvec", 32'(fvec[0]), 32'd3);
    seen = 0;
    repeat (30) begin
      @(negedge CLK);
      if (done[0]) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // reset mid-sweep, then a clean sweep
    mode[0] = 0;
    pulse_start();
    wait_stim0(3'd5);
    #2;
    R = 1'b0;
    #1;
    chk("mid_rst_stim", 32'(stim[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_err", 32'(err[0]), 32'd0);
    chk("mid_rst_fval", 32'(fval[0]), 32'd0);
    @(negedge CLK);
    R = 1'b1;
    repeat (30) @(negedge CLK);
    pulse_start();
    wait_done0("post_rst", n);
    chk("post_rst_pass", 32'(pass[0]), 32'd1);
    repeat (30) @(negedge CLK);

    // randomized traffic
    for (int i = 0; i < NI; i++) mode[i] = 4;
    repeat (1500) begin
      for (int i = 0; i < NI; i++) rnd_y[i] = 1'($urandom);
      start = ($urandom % 6) == 0;
      abort = ($urandom % 50) == 0;
      @(negedge CLK);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (40) @(negedge CLK);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
